// File: rtl/mem_arbiter_rr_pkg.sv
// mem_arbiter_rr_pkg
//   Shared cache-side definitions for the main-memory round-robin arbiter:
//   arbiter state encoding, requester index constants and default sizing.
//   Optional feature macro (used by mem_arbiter_rr): MEM_ARB_TIMEOUT_EN.
package mem_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_KILL = 2'd2
    } type_mem_arb_states_e;

    // Requester slots on the shared memory port
    localparam int REQ_DCACHE = 0;
    localparam int REQ_ICACHE = 1;
    localparam int REQ_PTW    = 2;

    localparam int NUM_REQ_DEF        = 3;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// mem_arbiter_rr_if
//   Bundles the requester-side and memory-side handshake of mem_arbiter_rr.
//   Signal names carry the arbiter's point of view (_i into it, _o out of it).
//   Modports:
//     slave  - the arbiter itself
//     master - the environment (caches, PTW and memory controller)
//   Requester side : req_i, addr_i, w_en_i, w_data_i, kill_i / ack_o, r_data_o, err_o
//   Memory side    : mem_req_o, mem_addr_o, mem_w_en_o, mem_w_data_o / mem_ack_i, mem_r_data_i
interface mem_arbiter_rr_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 128
);
    logic [NUM_REQ-1:0]             req_i;
    logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i;
    logic [NUM_REQ-1:0]             w_en_i;
    logic [NUM_REQ-1:0][DATA_W-1:0] w_data_i;
    logic [NUM_REQ-1:0]             kill_i;
    logic [NUM_REQ-1:0]             ack_o;
    logic [DATA_W-1:0]              r_data_o;
    logic [NUM_REQ-1:0]             err_o;

    logic                           mem_req_o;
    logic [ADDR_W-1:0]              mem_addr_o;
    logic                           mem_w_en_o;
    logic [DATA_W-1:0]              mem_w_data_o;
    logic                           mem_ack_i;
    logic [DATA_W-1:0]              mem_r_data_i;

    modport slave (
        input  req_i, addr_i, w_en_i, w_data_i, kill_i, mem_ack_i, mem_r_data_i,
        output ack_o, r_data_o, err_o, mem_req_o, mem_addr_o, mem_w_en_o, mem_w_data_o
    );

    modport master (
        output req_i, addr_i, w_en_i, w_data_i, kill_i, mem_ack_i, mem_r_data_i,
        input  ack_o, r_data_o, err_o, mem_req_o, mem_addr_o, mem_w_en_o, mem_w_data_o
    );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin priority encoder. Searches req_i starting at
//   ptr_i and wrapping around; the first asserted bit wins.
//   Ports:
//     req_i  [NUM_REQ]  request vector
//     ptr_i  [IDX_W]    highest-priority index this cycle (must be < NUM_REQ)
//     idx_o  [IDX_W]    winning index (0 when nothing is requested)
//     vld_o             at least one request present
module rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               vld_o
);
    int cand;

    // Walk offsets from farthest to nearest so the closest requester to
    // ptr_i is the last (and therefore final) assignment.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        cand  = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(ptr_i) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (req_i[cand]) begin
                idx_o = IDX_W'(cand);
                vld_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
//   Round-robin arbiter sharing one main-memory port among NUM_REQ cache-line
//   requesters (0 = dcache, 1 = icache, 2 = PTW by default). One beat per
//   transaction, zero-cycle grant from ARB_IDLE, ack/data combinational from
//   the memory response, per-requester kill of in-flight reads.
//   Ports:
//     clk_i  clock, rising edge
//     rst_i  asynchronous active-high reset; forces every output to 0
//     bus    mem_arbiter_rr_if.slave (requester and memory handshakes)
//   Optional feature: define MEM_ARB_TIMEOUT_EN for a no-ack watchdog of
//   TIMEOUT_CYCLES cycles that reports err_o to the owner. Without it err_o is
//   always 0 and the arbiter waits for the memory indefinitely.
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int NUM_REQ        = NUM_REQ_DEF,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 128,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_arbiter_rr_if.slave   bus
);
    localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("mem_arbiter_rr: TIMEOUT_CYCLES must be at least 2");
    end

    type_mem_arb_states_e state_q;
    logic [IDX_W-1:0]     owner_q;
    logic [IDX_W-1:0]     rr_ptr_q;

    logic [IDX_W-1:0]     win_idx;
    logic                 win_vld;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     owner_nxt;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_wen;
    logic                 own_kill;
    logic                 drive_mem;
    logic                 timeout;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i (bus.req_i),
        .ptr_i (rr_ptr_q),
        .idx_o (win_idx),
        .vld_o (win_vld)
    );

    // In IDLE the winner drives memory directly (0-cycle grant); afterwards
    // the registered owner does.
    assign sel_idx   = (state_q == ARB_IDLE) ? win_idx : owner_q;
    assign sel_addr  = bus.addr_i[sel_idx];
    assign sel_wdata = bus.w_data_i[sel_idx];
    assign sel_wen   = bus.w_en_i[sel_idx];

    // Kill only applies to reads; a writeback always completes.
    assign own_kill  = bus.kill_i[owner_q] & ~bus.w_en_i[owner_q];
    assign owner_nxt = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    assign drive_mem = ((state_q == ARB_IDLE) && win_vld) ||
                       ((state_q == ARB_BUSY) && !own_kill);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The counter sits at 0 in IDLE, so it is clear on entry to BUSY; the
    // BUSY->KILL transition clears it again. Firing on the incremented value
    // makes the error land TIMEOUT_CYCLES-1 cycles after the grant.
    assign cnt_d   = cnt_q + 1'b1;
    assign timeout = (state_q != ARB_IDLE) && !bus.mem_ack_i && (cnt_d == CNT_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if ((state_q == ARB_IDLE) || timeout || bus.mem_ack_i ||
                     ((state_q == ARB_BUSY) && own_kill)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Outputs are gated by reset so an in-flight transaction vanishes at once.
    always_comb begin
        bus.mem_req_o    = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_w_en_o   = 1'b0;
        bus.mem_w_data_o = '0;
        bus.ack_o        = '0;
        bus.err_o        = '0;
        bus.r_data_o     = '0;
        if (!rst_i) begin
            if (drive_mem) begin
                bus.mem_req_o    = 1'b1;
                bus.mem_addr_o   = sel_addr;
                bus.mem_w_en_o   = sel_wen;
                bus.mem_w_data_o = sel_wdata;
            end
            if ((state_q == ARB_BUSY) && !own_kill) begin
                if (bus.mem_ack_i) begin
                    bus.ack_o[owner_q] = 1'b1;
                    bus.r_data_o       = bus.mem_r_data_i;
                end
                if (timeout) begin
                    bus.err_o[owner_q] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (win_vld) begin
                        owner_q <= win_idx;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // Ack with a same-cycle kill also lands here; the comb
                    // block has already suppressed ack_o.
                    if (bus.mem_ack_i || timeout) begin
                        rr_ptr_q <= owner_nxt;
                        state_q  <= ARB_IDLE;
                    end else if (own_kill) begin
                        state_q  <= ARB_KILL;
                    end
                end
                ARB_KILL: begin
                    if (bus.mem_ack_i || timeout) begin
                        rr_ptr_q <= owner_nxt;
                        state_q  <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end
endmodule
